// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - multi-cycle load/store responder with a one-cycle mem_ready pulse
// Define MIPS_DMEM_BOUNDS_CHECK_EN to fault addresses outside [base_addr, base_addr+depth_words).
module mips_dmem_responder #(
  parameter logic [29:0] base_addr   = 30'h04000000,
  parameter int          depth_words = 1024,
  parameter int          latency     = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_en,
  output logic [31:0] mem_data_out,
  output logic        mem_excpt,
  output logic        mem_ready,
  output logic        mem_busy
);
  localparam int aw = $clog2(depth_words);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [3:0]    count;
  logic [aw-1:0] idx_q;
  logic [31:0]   data_q;
  logic [3:0]    mask_q;
  logic [31:0]   mem [depth_words];
  logic [aw-1:0] idx_in;
  logic          in_range;
  logic [31:0]   merged;
  logic          do_access;

  assign idx_in = aw'(mem_addr - base_addr);

`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
  logic excpt_q;
  // Unsigned wrap makes addresses below base_addr look huge, so one compare covers both bounds.
  assign in_range  = (mem_addr - base_addr) < 30'(depth_words);
  assign mem_excpt = excpt_q;
`else
  assign in_range  = 1'b1;
  assign mem_excpt = 1'b0;
`endif

  always_comb begin
    merged = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  assign do_access = (state == WAIT) && (count == 4'd0);

  // Array is deliberately left out of reset; only the control path clears.
  always_ff @(posedge clk) begin
    if (do_access) mem[idx_q] <= merged;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      count        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      mem_busy     <= 1'b0;
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
      excpt_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            idx_q    <= idx_in;
            data_q   <= mem_data_in;
            mask_q   <= mem_write_en;
            mem_busy <= 1'b1;
            if (in_range) begin
              count <= 4'(latency - 1);
              state <= WAIT;
            end else begin
              state     <= DONE;
              mem_ready <= 1'b1;
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
              excpt_q   <= 1'b1;
`endif
            end
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            mem_data_out <= merged;
            mem_ready    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          mem_busy  <= 1'b0;
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
          excpt_q   <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - randomized self-checking bench for mips_dmem_responder
module tb_mips_dmem_responder;
  localparam logic [29:0] BASE  = 30'h04000000;
  localparam int          DEPTH = 1024;
  localparam int          L     = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        mem_req = 1'b0;
  logic [29:0] mem_addr = '0;
  logic [31:0] mem_data_in = '0;
  logic [3:0]  mem_write_en = '0;
  logic [31:0] mem_data_out;
  logic        mem_excpt;
  logic        mem_ready;
  logic        mem_busy;

  int checks = 0;
  int errors = 0;

  mips_dmem_responder #(.base_addr(BASE), .depth_words(DEPTH), .latency(L)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out), .mem_excpt(mem_excpt),
    .mem_ready(mem_ready), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic addr_faults(input logic [29:0] a);
    logic f;
    f = (a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 31'(DEPTH)));
`ifndef MIPS_DMEM_BOUNDS_CHECK_EN
    f = 1'b0;
`endif
    return f;
  endfunction

  function automatic int addr_index(input logic [29:0] a);
    logic [29:0] d;
    d = a - BASE;
    return int'(d) % DEPTH;
  endfunction

  // Reference model: a request accepted at edge n completes at edge n+L (n for a fault),
  // stays busy through that completion, and the next accept may happen at completion+2.
  logic [31:0] mm [DEPTH];
  int          edge_n = 0, acc_edge = 0, done_edge = 0, p_idx = 0;
  bit          have = 0, p_fault = 0;
  logic [31:0] p_data = '0;
  logic [3:0]  p_mask = '0;
  logic        m_ready = 0, m_excpt = 0, m_busy = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      have = 0; m_ready = 0; m_excpt = 0; m_busy = 0; m_data = '0;
    end else begin
      edge_n++;
      m_ready = 0;
      m_excpt = 0;
      if (have && edge_n == done_edge) begin
        if (!p_fault) begin
          for (int b = 0; b < 4; b++)
            if (p_mask[b]) mm[p_idx][8*b +: 8] = p_data[8*b +: 8];
          m_data = mm[p_idx];
        end
        m_ready = 1;
        m_excpt = p_fault;
      end
      if (mem_req && (!have || edge_n >= done_edge + 2)) begin
        have     = 1;
        acc_edge = edge_n;
        p_idx    = addr_index(mem_addr);
        p_data   = mem_data_in;
        p_mask   = mem_write_en;
        p_fault  = addr_faults(mem_addr);
        if (p_fault) begin
          done_edge = edge_n;
          m_ready   = 1;
          m_excpt   = 1;
        end else begin
          done_edge = edge_n + L;
        end
      end
      m_busy = have && edge_n >= acc_edge && edge_n <= done_edge;
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(mem_ready), 32'(m_ready));
    check("excpt", 32'(mem_excpt), 32'(m_excpt));
    check("busy", 32'(mem_busy), 32'(m_busy));
    check("data_out", mem_data_out, m_data);
  end

  task automatic txn(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output logic rex, output int cyc);
    bit got;
    got = 0;
    @(negedge clk);
    #1;
    mem_req = 1; mem_addr = a; mem_data_in = d; mem_write_en = m;
    @(posedge clk);
    #1;
    mem_req = 0;
    cyc = 0; rd = '0; rex = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (mem_ready) begin
        got = 1; rd = mem_data_out; rex = mem_excpt;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no mem_ready expected one for addr %h", a);
    end
  endtask

  function automatic logic [29:0] pick_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return BASE + 30'(r);
    else if (r < 18) return BASE + 30'(DEPTH - 1);
    else if (r == 18) return BASE + 30'(DEPTH);
    else return BASE - 30'd1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, w;
    logic        rex;
    int          cyc, pulses;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_excpt", 32'(mem_excpt), 32'd0);
    check("rst_data", mem_data_out, 32'd0);
    #1 rst_b = 1;

    for (int i = 0; i < 17; i++) begin
      w = $urandom;
      txn(BASE + 30'(i == 16 ? DEPTH - 1 : i), w, 4'hF, rd, rex, cyc);
      check("init_store", rd, w);
    end

    txn(30'h04000005, 32'hDEADBEEF, 4'hF, rd, rex, cyc);
    check("store_cycle", 32'(cyc), 32'd3);
    check("store_data", rd, 32'hDEADBEEF);
    txn(30'h04000005, 32'h0, 4'h0, rd, rex, cyc);
    check("load_data", rd, 32'hDEADBEEF);
    check("load_excpt", 32'(rex), 32'd0);
    check("load_cycle", 32'(cyc), 32'd3);

    txn(30'h04000005, 32'h000000AA, 4'b0001, rd, rex, cyc);
    check("partial_store", rd, 32'hDEADBEAA);
    txn(30'h04000005, 32'h0, 4'h0, rd, rex, cyc);
    check("partial_load", rd, 32'hDEADBEAA);

`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
    txn(30'h04000400, 32'h0, 4'h0, rd, rex, cyc);
    check("oob_cycle", 32'(cyc), 32'd1);
    check("oob_excpt", 32'(rex), 32'd1);
    check("oob_data_held", rd, 32'hDEADBEAA);
    txn(30'h040003FF, 32'h0, 4'h0, rd, rex, cyc);
    check("top_excpt", 32'(rex), 32'd0);
    check("top_cycle", 32'(cyc), 32'd3);
`else
    txn(30'h04000400, 32'h12345678, 4'hF, rd, rex, cyc);
    check("alias_store_excpt", 32'(rex), 32'd0);
    txn(30'h04000000, 32'h0, 4'h0, rd, rex, cyc);
    check("alias_load", rd, 32'h12345678);
`endif

    @(negedge clk);
    #1;
    mem_req = 1; mem_addr = BASE + 30'd3; mem_write_en = 4'h0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    #1 mem_req = 0;
    check("busy_spacing", 32'(pulses), 32'd10);

    @(negedge clk);
    #1;
    mem_req = 1; mem_addr = 30'h04000005; mem_data_in = 32'h55555555; mem_write_en = 4'hF;
    @(posedge clk);
    #1 mem_req = 0;
    @(negedge clk);
    check("wait_busy", 32'(mem_busy), 32'd1);
    #1 rst_b = 0;
    @(negedge clk);
    check("midrst_busy", 32'(mem_busy), 32'd0);
    check("midrst_data", mem_data_out, 32'd0);
    #1 rst_b = 1;
    txn(30'h04000005, 32'h0, 4'h0, rd, rex, cyc);
    check("dropped_store", rd, 32'hDEADBEAA);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      rst_b        = ($urandom_range(0, 299) != 0);
      mem_req      = ($urandom_range(0, 9) < 6);
      mem_addr     = pick_addr();
      mem_data_in  = $urandom;
      mem_write_en = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    #1;
    mem_req = 0;
    rst_b   = 1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
